// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- iterative 32-bit integer divider (signed or unsigned)
//
// Restoring shift/subtract divider that produces one quotient bit per clock,
// MSB first, on operand magnitudes. Signs are re-applied when the result is
// loaded: the quotient is negated when the operand signs differ, and the
// remainder takes the sign of the dividend (truncation toward zero).
// A zero divisor skips the iteration and completes on the accepting edge with
// quotient = all ones, remainder = dividend and div_by_zero set.
//
// Ports
//   clk          rising-edge clock for all state
//   rst          asynchronous active-high reset
//   start        divide request, only looked at in IDLE
//   unsigned_op  1 = unsigned divide, 0 = two's-complement signed divide
//   OP_A         dividend, captured with start
//   OP_B         divisor, captured with start
//   busy         high while the iteration runs
//   done         one-cycle pulse, quotient/remainder valid in that cycle
//   quotient     result destined for lo
//   remainder    result destined for hi
//   div_by_zero  set with done for a zero divisor, cleared on the next
//                accepted start
// -----------------------------------------------------------------------------
module div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        unsigned_op,
   input  logic [31:0] OP_A,
   input  logic [31:0] OP_B,
   output logic        busy,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        div_by_zero
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Absolute value of an operand; unsigned operands pass through untouched.
   function automatic logic [31:0] magnitude(input logic [31:0] value,
                                             input logic        is_signed);
      logic [31:0] result;
      if (is_signed && value[31]) begin
         result = ~value + 32'd1;
      end else begin
         result = value;
      end
      return result;
   endfunction

   // Conditional two's-complement negation used to restore result signs.
   function automatic logic [31:0] apply_sign(input logic [31:0] value,
                                              input logic        negate);
      logic [31:0] result;
      if (negate) begin
         result = ~value + 32'd1;
      end else begin
         result = value;
      end
      return result;
   endfunction

   state_e      state_q,     state_d;
   logic [4:0]  cnt_q,       cnt_d;
   // work_q starts as the dividend magnitude; its MSB is shifted into the
   // partial remainder each step while the new quotient bit enters at the LSB,
   // so after 32 steps it holds the quotient magnitude.
   logic [31:0] work_q,      work_d;
   logic [31:0] divisor_q,   divisor_d;
   // The partial remainder is always below the divisor, so 32 stored bits
   // suffice; the shifted value and the trial subtraction are 33 bits wide.
   logic [31:0] rem_q,       rem_d;
   logic        neg_quo_q,   neg_quo_d;
   logic        neg_rem_q,   neg_rem_d;
   logic [31:0] quotient_q,  quotient_d;
   logic [31:0] remainder_q, remainder_d;
   logic        dbz_q,       dbz_d;
   logic        busy_q,      busy_d;
   logic        done_q,      done_d;

   logic [32:0] shift_rem;
   logic [32:0] trial;
   logic        qbit;
   logic [31:0] step_rem;
   logic [31:0] step_work;

   // One restoring step: shift in the next dividend bit, try the subtraction,
   // keep it only when it does not go negative.
   always_comb begin
      shift_rem = {rem_q, work_q[31]};
      trial     = shift_rem - {1'b0, divisor_q};
      qbit      = ~trial[32];
      if (qbit) begin
         step_rem = trial[31:0];
      end else begin
         step_rem = shift_rem[31:0];
      end
      step_work = {work_q[30:0], qbit};
   end

   // Next-state and datapath control for the IDLE/RUN/DONE sequence.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      work_d      = work_q;
      divisor_d   = divisor_q;
      rem_d       = rem_q;
      neg_quo_d   = neg_quo_q;
      neg_rem_d   = neg_rem_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (OP_B == 32'd0) begin
                  // Zero divisor completes immediately without iterating.
                  state_d     = ST_DONE;
                  quotient_d  = 32'hFFFF_FFFF;
                  remainder_d = OP_A;
                  dbz_d       = 1'b1;
               end else begin
                  state_d   = ST_RUN;
                  cnt_d     = 5'd0;
                  work_d    = magnitude(OP_A, ~unsigned_op);
                  divisor_d = magnitude(OP_B, ~unsigned_op);
                  rem_d     = 32'd0;
                  neg_quo_d = ~unsigned_op & (OP_A[31] ^ OP_B[31]);
                  neg_rem_d = ~unsigned_op & OP_A[31];
                  dbz_d     = 1'b0;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            rem_d  = step_rem;
            work_d = step_work;
            if (cnt_q == 5'd31) begin
               // Last step: results are loaded on the same edge that enters DONE.
               state_d     = ST_DONE;
               quotient_d  = apply_sign(step_work, neg_quo_q);
               remainder_d = apply_sign(step_rem, neg_rem_q);
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Status flags are registered from the next state so they line up
      // exactly with the state they describe.
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   // State, datapath and output registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 5'd0;
         work_q      <= 32'd0;
         divisor_q   <= 32'd0;
         rem_q       <= 32'd0;
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         quotient_q  <= 32'd0;
         remainder_q <= 32'd0;
         dbz_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         work_q      <= work_d;
         divisor_q   <= divisor_d;
         rem_q       <= rem_d;
         neg_quo_q   <= neg_quo_d;
         neg_rem_q   <= neg_rem_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit -- directed self-checking bench for div_unit.
// Expected values below are hand-computed from the divider's definition.
// Latency is counted in rising edges after the accepting edge: 32 for a normal
// divide (done in the cycle after edge 32), 0 for a zero divisor (done in the
// cycle right after the accepting edge).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_div_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic        unsigned_op;
   logic [31:0] OP_A;
   logic [31:0] OP_B;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   int n_cmp = 0;
   int n_mis = 0;
   int cyc   = 0;
   int t0    = 0;

   div_unit dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .unsigned_op (unsigned_op),
      .OP_A        (OP_A),
      .OP_B        (OP_B),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running edge counter used to measure latency.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present a request for one cycle; returns #1 after the accepting edge.
   // Operands are scrambled afterwards to show they were captured.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic uns);
      @(negedge clk);
      OP_A        = a;
      OP_B        = b;
      unsigned_op = uns;
      start       = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      OP_A  = ~a;
      OP_B  = 32'h1234_5678;
      unsigned_op = ~uns;
      t0    = cyc;
   endtask

   // Wait (bounded) for done; report edges since the accept and busy cycles seen.
   task automatic wait_done(input string tag, output int lat, output int bcnt);
      int n;
      n    = 0;
      bcnt = 0;
      while (done !== 1'b1 && n < 100) begin
         if (busy === 1'b1) bcnt++;
         @(posedge clk);
         #1;
         n++;
      end
      lat = cyc - t0;
      if (done !== 1'b1) check_eq({tag, "_timeout"}, {31'd0, done}, 32'd1);
   endtask

   task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic uns, input logic [31:0] eq, input logic [31:0] er,
                         input logic ez, input int elat, input int ebusy);
      int lat;
      int bcnt;
      start_op(a, b, uns);
      wait_done(tag, lat, bcnt);
      check_eq({tag, "_lat"},  32'(lat),  32'(elat));
      check_eq({tag, "_busy_cycles"}, 32'(bcnt), 32'(ebusy));
      check_eq({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      check_eq({tag, "_quo"},  quotient,  eq);
      check_eq({tag, "_rem"},  remainder, er);
      check_eq({tag, "_dbz"},  {31'd0, div_by_zero}, {31'd0, ez});
      @(posedge clk);
      #1;
      check_eq({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      int lat;
      int bcnt;
      rst         = 1'b1;
      start       = 1'b0;
      unsigned_op = 1'b0;
      OP_A        = 32'd0;
      OP_B        = 32'd0;

      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_done", {31'd0, done}, 32'd0);
      check_eq("rst_quo",  quotient,  32'd0);
      check_eq("rst_rem",  remainder, 32'd0);
      check_eq("rst_dbz",  {31'd0, div_by_zero}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      do_div("u100_7",   32'd100,        32'd7,          1'b1, 32'd14,         32'd2,          1'b0, 32, 32);
      do_div("s-7_2",    32'hFFFF_FFF9,  32'd2,          1'b0, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 32, 32);
      do_div("s7_-2",    32'd7,          32'hFFFF_FFFE,  1'b0, 32'hFFFF_FFFD,  32'd1,          1'b0, 32, 32);
      do_div("s-100_-7", 32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b0, 32'd14,         32'hFFFF_FFFE,  1'b0, 32, 32);
      do_div("s5_0",     32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1'b1, 0,  0);
      do_div("smin_-1",  32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000,  32'd0,          1'b0, 32, 32);
      do_div("uffff_16", 32'hFFFF_FFFF,  32'd16,         1'b1, 32'h0FFF_FFFF,  32'd15,         1'b0, 32, 32);
      do_div("uffff_3",  32'hFFFF_FFFF,  32'd3,          1'b1, 32'h5555_5555,  32'd0,          1'b0, 32, 32);

      // A start while running is ignored and does not disturb the result.
      start_op(32'd1000, 32'd10, 1'b1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      OP_A  = 32'd9;
      OP_B  = 32'd3;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check_eq("ign_busy", {31'd0, busy}, 32'd1);
      wait_done("ign", lat, bcnt);
      check_eq("ign_lat", 32'(lat), 32'd32);
      check_eq("ign_quo", quotient,  32'd100);
      check_eq("ign_rem", remainder, 32'd0);
      @(posedge clk);
      #1;
      check_eq("ign_done_pulse", {31'd0, done}, 32'd0);

      // Reset in the middle of a run clears everything at once, no done pulse.
      start_op(32'd1000, 32'd10, 1'b1);
      check_eq("abort_hold_quo", quotient, 32'd100);
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("abort_busy", {31'd0, busy}, 32'd0);
      check_eq("abort_done", {31'd0, done}, 32'd0);
      check_eq("abort_quo",  quotient,  32'd0);
      check_eq("abort_rem",  remainder, 32'd0);
      check_eq("abort_dbz",  {31'd0, div_by_zero}, 32'd0);
      repeat (2) begin
         @(posedge clk);
         #1;
         check_eq("abort_no_done", {31'd0, done}, 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      do_div("post_rst_9_3", 32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 1'b0, 32, 32);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
